// File: rtl/core_pkg.sv
// Shared definitions for the MIPS32 core: datapath widths, ALU opcodes and the
// control-bit bundle carried between pipeline stages.
package core_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int ALU_OP_W_DEF   = 4;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic branch;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_hazard.sv
// Load-use compare between the instruction in EX and the one in ID.
// Purely combinational so the hazard unit can instantiate it directly.
module id_ex_hazard
    import core_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_wb_addr,
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    input  logic                  id_rt_used,
    output logic                  load_use
);

    logic dst_live;
    logic rs_hit;
    logic rt_hit;

    // A load targeting $0 never produces a value anyone waits for.
    assign dst_live = ex_valid && ex_mem_read && (ex_wb_addr != REG_ADDR_W'(REG_ZERO));
    assign rs_hit   = (ex_wb_addr == id_rs_addr);
    assign rt_hit   = id_rt_used && (ex_wb_addr == id_rt_addr);
    assign load_use = dst_live && (rs_hit || rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall, flush and bubble insertion plus load-use detection.
// Optional build macro ID_EX_STATS_EN adds a 32-bit bubble counter output.
module id_ex_stage
    import core_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int ALU_OP_W   = ALU_OP_W_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic                  i_valid,
    input  logic [DATA_W-1:0]     i_pc,
    input  logic [DATA_W-1:0]     i_rs_data,
    input  logic [DATA_W-1:0]     i_rt_data,
    input  logic [DATA_W-1:0]     i_imm,
    input  logic [REG_ADDR_W-1:0] i_rs_addr,
    input  logic [REG_ADDR_W-1:0] i_rt_addr,
    input  logic [REG_ADDR_W-1:0] i_rd_addr,
    input  logic                  i_rt_used,
    input  logic [ALU_OP_W-1:0]   i_alu_op,
    input  logic                  i_alu_src,
    input  logic                  i_reg_dst,
    input  logic                  i_reg_write,
    input  logic                  i_mem_read,
    input  logic                  i_mem_write,
    input  logic                  i_mem_to_reg,
    input  logic                  i_branch,
    output logic                  o_valid,
    output logic [DATA_W-1:0]     o_pc,
    output logic [DATA_W-1:0]     o_rs_data,
    output logic [DATA_W-1:0]     o_rt_data,
    output logic [DATA_W-1:0]     o_imm,
    output logic [REG_ADDR_W-1:0] o_rs_addr,
    output logic [REG_ADDR_W-1:0] o_rt_addr,
    output logic [REG_ADDR_W-1:0] o_wb_addr,
    output logic [ALU_OP_W-1:0]   o_alu_op,
    output logic                  o_alu_src,
    output logic                  o_reg_write,
    output logic                  o_mem_read,
    output logic                  o_mem_write,
    output logic                  o_mem_to_reg,
    output logic                  o_branch,
    output logic                  o_load_use
`ifdef ID_EX_STATS_EN
    ,
    output logic [31:0]           o_bubble_cnt
`endif
);

    function automatic logic [REG_ADDR_W-1:0] resolve_wb(
        input logic                  reg_dst,
        input logic [REG_ADDR_W-1:0] rd_addr,
        input logic [REG_ADDR_W-1:0] rt_addr
    );
        return reg_dst ? rd_addr : rt_addr;
    endfunction

    logic                  vld_p1;
    ctrl_t                 ctrl_p1;
    logic [DATA_W-1:0]     pc_p1;
    logic [DATA_W-1:0]     rs_data_p1;
    logic [DATA_W-1:0]     rt_data_p1;
    logic [DATA_W-1:0]     imm_p1;
    logic [REG_ADDR_W-1:0] rs_addr_p1;
    logic [REG_ADDR_W-1:0] rt_addr_p1;
    logic [REG_ADDR_W-1:0] wb_addr_p1;
    logic [ALU_OP_W-1:0]   alu_op_p1;
    logic                  alu_src_p1;

    logic [REG_ADDR_W-1:0] wb_addr_p0;
    ctrl_t                 ctrl_p0;
    logic                  bubble_p0;

    assign wb_addr_p0 = resolve_wb(i_reg_dst, i_rd_addr, i_rt_addr);

    // Writes to $0 are dropped here so later stages never see them.
    always_comb begin
        ctrl_p0            = CTRL_NOP;
        ctrl_p0.reg_write  = i_reg_write && (wb_addr_p0 != REG_ADDR_W'(REG_ZERO));
        ctrl_p0.mem_read   = i_mem_read;
        ctrl_p0.mem_write  = i_mem_write;
        ctrl_p0.mem_to_reg = i_mem_to_reg;
        ctrl_p0.branch     = i_branch;
    end

    // A flush wins over stall; an empty ID slot loads as a bubble unless stalled.
    assign bubble_p0 = i_flush || (!i_stall && !i_valid);

    // ---- ID -> EX boundary ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p1     <= 1'b0;
            ctrl_p1    <= CTRL_NOP;
            pc_p1      <= '0;
            rs_data_p1 <= '0;
            rt_data_p1 <= '0;
            imm_p1     <= '0;
            rs_addr_p1 <= '0;
            rt_addr_p1 <= '0;
            wb_addr_p1 <= '0;
            alu_op_p1  <= '0;
            alu_src_p1 <= 1'b0;
        end else if (bubble_p0) begin
            vld_p1     <= 1'b0;
            ctrl_p1    <= CTRL_NOP;
            pc_p1      <= '0;
            rs_data_p1 <= '0;
            rt_data_p1 <= '0;
            imm_p1     <= '0;
            rs_addr_p1 <= '0;
            rt_addr_p1 <= '0;
            wb_addr_p1 <= '0;
            alu_op_p1  <= '0;
            alu_src_p1 <= 1'b0;
        end else if (!i_stall) begin
            vld_p1     <= 1'b1;
            ctrl_p1    <= ctrl_p0;
            pc_p1      <= i_pc;
            rs_data_p1 <= i_rs_data;
            rt_data_p1 <= i_rt_data;
            imm_p1     <= i_imm;
            rs_addr_p1 <= i_rs_addr;
            rt_addr_p1 <= i_rt_addr;
            wb_addr_p1 <= wb_addr_p0;
            alu_op_p1  <= i_alu_op;
            alu_src_p1 <= i_alu_src;
        end
    end

`ifdef ID_EX_STATS_EN
    logic [31:0] bubble_cnt_p1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bubble_cnt_p1 <= '0;
        end else if (bubble_p0) begin
            bubble_cnt_p1 <= bubble_cnt_p1 + 32'd1;
        end
    end

    assign o_bubble_cnt = bubble_cnt_p1;
`endif

    assign o_valid      = vld_p1;
    assign o_pc         = pc_p1;
    assign o_rs_data    = rs_data_p1;
    assign o_rt_data    = rt_data_p1;
    assign o_imm        = imm_p1;
    assign o_rs_addr    = rs_addr_p1;
    assign o_rt_addr    = rt_addr_p1;
    assign o_wb_addr    = wb_addr_p1;
    assign o_alu_op     = alu_op_p1;
    assign o_alu_src    = alu_src_p1;
    assign o_reg_write  = ctrl_p1.reg_write;
    assign o_mem_read   = ctrl_p1.mem_read;
    assign o_mem_write  = ctrl_p1.mem_write;
    assign o_mem_to_reg = ctrl_p1.mem_to_reg;
    assign o_branch     = ctrl_p1.branch;

    id_ex_hazard #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard (
        .ex_valid    (vld_p1),
        .ex_mem_read (ctrl_p1.mem_read),
        .ex_wb_addr  (wb_addr_p1),
        .id_rs_addr  (i_rs_addr),
        .id_rt_addr  (i_rt_addr),
        .id_rt_used  (i_rt_used),
        .load_use    (o_load_use)
    );

endmodule
